// File: rtl/cascade_digit_counter_pkg.sv
// Shared definitions for the cascaded digit counter: FSM encoding,
// default digit width, standard modulus sets and the control FSM step.
package cascade_digit_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W_DEF = 4;

  // Packed per-digit moduli, digit 0 in the low nibble.
  localparam logic [15:0] MODULI_MM_SS = {4'd6, 4'd10, 4'd6, 4'd10};
  localparam logic [15:0] MODULI_HH_MM = {4'd3, 4'd10, 4'd6, 4'd10};
  localparam logic [15:0] MODULI_SS_CC = {4'd6, 4'd10, 4'd10, 4'd10};

  // Next state for the run/pause control. clear and load are applied by the
  // caller because they dominate; stop outranks start_resume.
  function automatic state_e fsm_step(input state_e cur, input logic start_resume,
                                      input logic stop);
    state_e nxt;
    nxt = cur;
    if (stop) begin
      if (cur == ST_RUNNING) begin
        nxt = ST_PAUSED;
      end else begin
        nxt = cur;
      end
    end else if (start_resume) begin
      case (cur)
        ST_IDLE:    nxt = ST_RUNNING;
        ST_RUNNING: nxt = ST_PAUSED;
        ST_PAUSED:  nxt = ST_RUNNING;
        default:    nxt = ST_IDLE;
      endcase
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cascade_digit_counter_mod_digit.sv
// One modulo-MOD digit: up/down step, parallel load with out-of-range
// clamp to zero, and synchronous clear. terminal/wrap are combinational.
module mod_digit
  import cascade_digit_counter_pkg::*;
#(
  parameter int unsigned          DIGIT_W = DIGIT_W_DEF,
  parameter logic [DIGIT_W-1:0]   MOD     = DIGIT_W'(10)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               clr,
  output logic [DIGIT_W-1:0] value,
  output logic               terminal,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] TOP  = MOD - DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] ZERO = DIGIT_W'(0);
  localparam logic [DIGIT_W-1:0] ONE  = DIGIT_W'(1);

  logic [DIGIT_W-1:0] value_q;
  logic [DIGIT_W-1:0] value_d;

  // Terminal value depends on direction: top when counting up, zero when down.
  always_comb begin
    if (dir) begin
      terminal = (value_q == ZERO);
    end else begin
      terminal = (value_q == TOP);
    end
    wrap  = en & terminal;
    value = value_q;
  end

  // Next digit value: clear beats load beats counting.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = ZERO;
    end else if (load) begin
      if (load_val >= MOD) begin
        value_d = ZERO;
      end else begin
        value_d = load_val;
      end
    end else if (en) begin
      if (dir) begin
        value_d = (value_q == ZERO) ? TOP : (value_q - ONE);
      end else begin
        value_d = (value_q == TOP) ? ZERO : (value_q + ONE);
      end
    end else begin
      value_d = value_q;
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= ZERO;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/cascade_digit_counter.sv
// Chain of modulo-M digits with run/pause FSM, load, lap capture and
// registered per-digit and whole-chain wrap pulses.
module cascade_digit_counter
  import cascade_digit_counter_pkg::*;
#(
  parameter int unsigned                    NUM_DIGITS = 4,
  parameter int unsigned                    DIGIT_W    = DIGIT_W_DEF,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]  MODULI     = {4'd6, 4'd10, 4'd6, 4'd10}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          start_resume,
  input  logic                          stop,
  input  logic                          clear,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
  input  logic                          dir,
  input  logic                          lap,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic [NUM_DIGITS*DIGIT_W-1:0] lap_count,
  output logic                          lap_valid,
  output logic [NUM_DIGITS-1:0]         digit_carry,
  output logic                          carry_out,
  output logic                          running
);

  localparam int unsigned CW = NUM_DIGITS * DIGIT_W;

  state_e                state_q, state_d;
  logic [CW-1:0]         lap_count_q, lap_count_d;
  logic                  lap_valid_q, lap_valid_d;
  logic [NUM_DIGITS-1:0] digit_carry_q, digit_carry_d;
  logic                  carry_out_q, carry_out_d;

  logic                  count_en_s;
  logic [NUM_DIGITS:0]   chain_s;
  logic [NUM_DIGITS-1:0] terminal_s;
  logic [NUM_DIGITS-1:0] wrap_s;
  logic [CW-1:0]         count_s;

  // A tick counts only in RUNNING and only when no higher-priority pulse is present.
  always_comb begin
    count_en_s = tick & (state_q == ST_RUNNING) & ~clear & ~load & ~stop & ~start_resume;
    chain_s[0] = count_en_s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      chain_s[i+1] = chain_s[i] & terminal_s[i];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    mod_digit #(
      .DIGIT_W (DIGIT_W),
      .MOD     (MODULI[g*DIGIT_W +: DIGIT_W])
    ) u_digit (
      .clk      (clk),
      .reset    (reset),
      .en       (chain_s[g]),
      .dir      (dir),
      .load     (load),
      .load_val (load_value[g*DIGIT_W +: DIGIT_W]),
      .clr      (clear),
      .value    (count_s[g*DIGIT_W +: DIGIT_W]),
      .terminal (terminal_s[g]),
      .wrap     (wrap_s[g])
    );
  end

  // FSM next state, lap capture and carry pulses for this edge.
  always_comb begin
    state_d       = state_q;
    lap_count_d   = lap_count_q;
    lap_valid_d   = lap_valid_q;
    digit_carry_d = wrap_s;
    carry_out_d   = chain_s[NUM_DIGITS];
    if (clear) begin
      state_d     = ST_IDLE;
      lap_count_d = '0;
      lap_valid_d = 1'b0;
    end else begin
      if (load) begin
        state_d = ST_PAUSED;
      end else begin
        state_d = fsm_step(state_q, start_resume, stop);
      end
      if (lap && (state_q != ST_IDLE)) begin
        lap_count_d = count_s;
        lap_valid_d = 1'b1;
      end else begin
        lap_count_d = lap_count_q;
        lap_valid_d = lap_valid_q;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lap_count_q   <= '0;
      lap_valid_q   <= 1'b0;
      digit_carry_q <= '0;
      carry_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lap_count_q   <= lap_count_d;
      lap_valid_q   <= lap_valid_d;
      digit_carry_q <= digit_carry_d;
      carry_out_q   <= carry_out_d;
    end
  end

  assign count       = count_s;
  assign lap_count   = lap_count_q;
  assign lap_valid   = lap_valid_q;
  assign digit_carry = digit_carry_q;
  assign carry_out   = carry_out_q;
  assign running     = (state_q == ST_RUNNING);

endmodule
